ram_arbiter: RTL and testbench

//  Two-requester controller for the 4-word x 4-bit latch RAM (ram_wr, ram_addr, ram_in_data, ram_out_data).

---
 rtl/ram_ctrl_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 30 +++
 rtl/ram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
//   Shared definitions for the two-requester latch-RAM controller:
//   - default RAM geometry (address / data width)
//   - controller state encoding (raw localparams plus the enum built on them)
//   - operation encoding for the captured request type
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

    // Default geometry of the 4-word x 4-bit latch RAM.
    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 4;

    // Raw state codes. Kept as plain localparams so checkers and the debug
    // port can compare against a stable numeric value.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_SAMPLE = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        STROBE = ST_STROBE,
        HOLD   = ST_HOLD,
        SAMPLE = ST_SAMPLE,
        RESP   = ST_RESP
    } state_t;

    // Captured operation type.
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage : ram_ctrl_pkg

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant selection, purely combinational.
//   When both requesters are valid the one that did NOT win last time is
//   chosen; with a single valid requester that requester is chosen.
// Ports
//   valid0, valid1 : in  request pending from requester 0 / 1
//   last_grant     : in  index of the requester granted on the last accept
//   grant          : out index of the selected requester (0 when none valid)
//   grant_vld      : out at least one requester is valid
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_vld
);

    always_comb begin
        grant_vld = valid0 | valid1;
        grant     = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

endmodule : rr_arb2

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//   Two-requester controller for a small level-sensitive latch RAM.
//   Requests are arbitrated round-robin, then a fixed setup/strobe/hold
//   sequence is run so the write enable is never high while the address or
//   write data are changing. Completion is signalled with a one-cycle
//   response pulse carrying read data (zero for writes).
//
// Handshake (both requesters):
//   A requester raises reqN_valid and holds it, together with reqN_wr,
//   reqN_addr and reqN_wdata, until it sees reqN_ready=1 at a rising edge;
//   that edge is the accept and the fields are captured there. reqN_ready is
//   only ever high in IDLE, and never for both requesters at once. The
//   response rspN_valid is a single-cycle pulse with no back-pressure.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req0_* / req1_*     : request channels (valid/ready/wr/addr/wdata)
//   rsp0_* / rsp1_*     : one-cycle response pulse and read data
//   ram_wr/ram_addr/
//   ram_in_data         : registered RAM controls
//   ram_out_data        : combinational RAM read data
//   busy                : controller is not in IDLE
//   dbg_state           : current FSM state code (ram_ctrl_pkg ST_* values)
// ----------------------------------------------------------------------------
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in_data,
    input  logic [DATA_W-1:0] ram_out_data,

    output logic              busy,
    output logic [2:0]        dbg_state
);

    state_t state;
    state_t state_nx;

    logic last_grant;   // requester that won the most recent accept
    logic owner;        // requester that owns the in-flight transaction
    logic op;           // captured OP_RD / OP_WR

    logic grant;
    logic grant_vld;
    logic accept;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arb2 u_rr_arb2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_vld  (grant_vld)
    );

    // Ready depends only on state and the arbiter, never on ready itself,
    // so there is no combinational loop through the requesters.
    assign accept     = (state == IDLE) && grant_vld;
    assign req0_ready = accept && (grant == 1'b0);
    assign req1_ready = accept && (grant == 1'b1);

    // Fields of the granted requester, captured on accept.
    always_comb begin
        sel_wr    = req0_wr;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (grant) begin
            sel_wr    = req1_wr;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   state_nx = (op == OP_WR) ? STROBE : SAMPLE;
            STROBE:  state_nx = HOLD;
            HOLD:    state_nx = RESP;
            SAMPLE:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    //   All RAM-facing outputs and the response are registered from the
    //   next state, so each one changes only at a clock edge and the write
    //   enable is a clean single-cycle pulse aligned with STROBE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;   // requester 0 wins the first tie
            owner       <= 1'b0;
            op          <= OP_RD;
            ram_wr      <= 1'b0;
            ram_addr    <= '0;
            ram_in_data <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_rdata  <= '0;
            rsp1_rdata  <= '0;
        end else begin
            state <= state_nx;

            // Address and data are loaded at the accept edge and then held
            // untouched until the next accept, covering setup and hold.
            if (accept) begin
                last_grant  <= grant;
                owner       <= grant;
                op          <= sel_wr ? OP_WR : OP_RD;
                ram_addr    <= sel_addr;
                ram_in_data <= sel_wdata;
            end

            ram_wr <= (state_nx == STROBE);

            rsp0_valid <= (state_nx == RESP) && (owner == 1'b0);
            rsp1_valid <= (state_nx == RESP) && (owner == 1'b1);

            // The edge entering RESP from SAMPLE is the read-capture edge;
            // writes and idle cycles return zero data.
            rsp0_rdata <= ((state_nx == RESP) && (owner == 1'b0) && (op == OP_RD))
                          ? ram_out_data : '0;
            rsp1_rdata <= ((state_nx == RESP) && (owner == 1'b1) && (op == OP_RD))
                          ? ram_out_data : '0;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Embedded properties
    // ------------------------------------------------------------------
    a_ready_onehot : assert property (@(posedge clk) !(req0_ready && req1_ready));

    a_wr_only_in_strobe : assert property (
        @(posedge clk) disable iff (reset) ram_wr |-> (state == STROBE));

    a_rsp_onehot : assert property (
        @(posedge clk) disable iff (reset) !(rsp0_valid && rsp1_valid));

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//   Bench for ram_arbiter driving a behavioural 4x4 latch RAM.
//   Expected responses, latencies and write strobes are queued when a
//   transaction is accepted and checked by a negedge monitor.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;
    import ram_ctrl_pkg::*;

    localparam int AW = 2;
    localparam int DW = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUT + RAM
    // ------------------------------------------------------------------
    logic          req0_valid, req0_ready, req0_wr;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_wr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_in_data, ram_out_data;
    logic          busy;
    logic [2:0]    dbg_state;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_wr      (req0_wr),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_wr      (req1_wr),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .ram_wr       (ram_wr),
        .ram_addr     (ram_addr),
        .ram_in_data  (ram_in_data),
        .ram_out_data (ram_out_data),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Level-sensitive latch RAM: transparent while ram_wr is high.
    logic [DW-1:0] ram_mem [4];
    always @(ram_wr or ram_addr or ram_in_data) begin
        if (ram_wr) ram_mem[ram_addr] = ram_in_data;
    end
    assign ram_out_data = ram_mem[ram_addr];

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            lat_q0[$];
    int            lat_q1[$];
    int            strb_cyc_q[$];
    logic [AW-1:0] strb_adr_q[$];
    logic [DW-1:0] strb_dat_q[$];
    int            acc_log[$];

    logic [DW-1:0] model_mem [4];
    logic [AW-1:0] cur_addr = '0;
    int            last_acc [2];
    int            last_rsp0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_sb();
        exp_q0.delete(); exp_q1.delete();
        lat_q0.delete(); lat_q1.delete();
        strb_cyc_q.delete(); strb_adr_q.delete(); strb_dat_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Monitor (sampled on the falling edge)
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (busy) begin
                chk("ready_in_busy", {30'd0, req0_ready, req1_ready}, 32'd0);
                chk("addr_hold", {30'd0, ram_addr}, {30'd0, cur_addr});
            end
            if (ram_wr) begin
                if (strb_cyc_q.size() == 0) begin
                    chk("ram_wr_unexp", 32'd1, 32'd0);
                end else begin
                    chk("strobe_cycle", strb_cyc_q.pop_front(), cyc);
                    chk("strobe_addr", {30'd0, ram_addr}, {30'd0, strb_adr_q.pop_front()});
                    chk("strobe_data", {28'd0, ram_in_data}, {28'd0, strb_dat_q.pop_front()});
                end
            end
            chk("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid) begin
                if (exp_q0.size() == 0) begin
                    chk("rsp0_unexp", 32'd1, 32'd0);
                end else begin
                    chk("rsp0_latency", cyc, lat_q0.pop_front());
                    chk("rsp0_rdata", {28'd0, rsp0_rdata}, {28'd0, exp_q0.pop_front()});
                end
                last_rsp0 = cyc;
            end else begin
                chk("rsp0_rdata_idle", {28'd0, rsp0_rdata}, 32'd0);
            end
            if (rsp1_valid) begin
                if (exp_q1.size() == 0) begin
                    chk("rsp1_unexp", 32'd1, 32'd0);
                end else begin
                    chk("rsp1_latency", cyc, lat_q1.pop_front());
                    chk("rsp1_rdata", {28'd0, rsp1_rdata}, {28'd0, exp_q1.pop_front()});
                end
            end else begin
                chk("rsp1_rdata_idle", {28'd0, rsp1_rdata}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic set_req(input int n, input logic v, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Issue one transaction, wait (bounded) for accept, record expectations.
    task automatic do_txn(input int n, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited;
        bit got;
        logic [DW-1:0] ed;
        int lat;
        waited = 0;
        got = 1'b0;
        set_req(n, 1'b1, wr, a, d);
        while (!got && waited < 100) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                acc_log.push_back(n);
                last_acc[n] = cyc;
                cur_addr = a;
                if (wr) begin
                    model_mem[a] = d;
                    strb_cyc_q.push_back(cyc + 2);
                    strb_adr_q.push_back(a);
                    strb_dat_q.push_back(d);
                    ed  = '0;
                    lat = cyc + 4;
                end else begin
                    ed  = model_mem[a];
                    lat = cyc + 3;
                end
                if (n == 0) begin
                    exp_q0.push_back(ed); lat_q0.push_back(lat);
                end else begin
                    exp_q1.push_back(ed); lat_q1.push_back(lat);
                end
            end
            waited++;
        end
        if (!got) chk($sformatf("req%0d_accept_timeout", n), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        set_req(n, 1'b0, 1'b0, '0, '0);
    endtask

    // Wait (bounded) until all expected responses have arrived.
    task automatic drain();
        int k;
        k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", {31'd0, (k >= 50)}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_sb();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_addr", {30'd0, ram_addr}, 32'd0);
        chk("rst_ram_in_data", {28'd0, ram_in_data}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp0_rdata, rsp1_rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        last_acc[0] = 0;
        last_acc[1] = 0;
        do_reset();

        // 1/2: write A to address 2, then read it back.
        do_txn(0, 1'b1, 2'd2, 4'hA);
        drain();
        do_txn(0, 1'b0, 2'd2, 4'h0);
        drain();

        // 3: fill all words, then read each back.
        for (int i = 0; i < 4; i++) do_txn(0, 1'b1, i[AW-1:0], 4'(i + 1));
        for (int i = 0; i < 4; i++) do_txn(0, 1'b0, i[AW-1:0], 4'h0);
        drain();

        // 4: both requesters continuously valid, four writes each.
        do_reset();
        acc_log.delete();
        fork
            for (int i = 0; i < 4; i++) do_txn(0, 1'b1, i[AW-1:0], 4'(8 + i));
            for (int j = 0; j < 4; j++) do_txn(1, 1'b1, 2'(3 - j), 4'($urandom_range(0, 15)));
        join
        drain();
        chk("grant_count", acc_log.size(), 32'd8);
        for (int i = 0; i < acc_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), acc_log[i], i % 2);
        for (int i = 0; i < 4; i++) do_txn(i % 2, 1'b0, i[AW-1:0], 4'h0);
        drain();

        // 5: reset during the strobe of a write.
        do_txn(0, 1'b1, 2'd3, 4'hF);
        k = 0;
        while (dbg_state != ST_STROBE && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t5_strobe_seen", {29'd0, dbg_state}, {29'd0, ST_STROBE});
        reset = 1'b1;
        clear_sb();
        @(negedge clk);
        @(negedge clk);
        chk("t5_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("t5_ram_addr", {30'd0, ram_addr}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_txn(0, 1'b1, 2'd3, 4'h5);
        do_txn(0, 1'b0, 2'd3, 4'h0);
        do_txn(1, 1'b0, 2'd0, 4'h0);
        drain();

        // 6: requester 1 raises valid during requester 0's HOLD.
        fork
            do_txn(0, 1'b1, 2'd1, 4'h7);
            begin
                int m;
                m = 0;
                while (dbg_state != ST_HOLD && m < 50) begin
                    @(negedge clk);
                    m++;
                end
                do_txn(1, 1'b0, 2'd1, 4'h0);
            end
        join
        drain();
        chk("t6_accept_after_rsp", last_acc[1], last_rsp0 + 1);

        repeat (5) @(posedge clk);
        #1;
        chk("final_q0_empty", exp_q0.size(), 32'd0);
        chk("final_q1_empty", exp_q1.size(), 32'd0);
        chk("final_strobe_empty", strb_cyc_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ram_arbiter
